pssi_tx_burst_fifo: RTL and testbench
=====================================

Name: pssi_tx_burst_fifo

Overview:
Parametrised successor to the fixed 8-bit-bus / 32-bit-word PSSI sender. Buffers ADC sample words from the capture logic in a synchronous FIFO and serialises them to the STM32H7 PSSI receiver in bursts of BURST_LEN words. Bus width, word width, FIFO depth, PSSI clock divider and inter-burst gap are all parameters, and the block honours the receiver's RDY flow control. Sits between the ADS8681 capture path and the top-level PSSI pins; any tristating of DE/data is done at top level.

Parameters:
BUS_W, 8, PSSI data bus width; must be 8 or 16.
WORD_W, 32, sample word width; must be a multiple of BUS_W.
FIFO_DEPTH, 16, FIFO depth in words; must be a power of 2 and at least BURST_LEN.
BURST_LEN, 4, words sent per DE-asserted burst.
CLK_DIV, 4, clk_i cycles per pssi_clk_o period; must be even and at least 2.
GAP_CYC, 2, number of pssi_clk_o periods with DE low between bursts.

Ports:
clk_i  in  1  system clock; the only clock.
rst_i  in  1  synchronous reset, active-high.
wr_en_i  in  1  write strobe for one word per cycle.
wr_data_i  in  WORD_W  sample word to write.
full_o  out  1  FIFO is full.
level_o  out  clog2(FIFO_DEPTH)+1  FIFO occupancy in words.
overflow_o  out  1  sticky flag: a write was dropped; cleared only by rst_i.
busy_o  out  1  FSM is not in IDLE.
pssi_rdy_i  in  1  receiver ready (PSSI RDY); treat as synchronous to clk_i.
pssi_clk_o  out  1  PSSI clock, registered, 50% duty.
pssi_de_o  out  1  data enable; receiver samples on the rising edge of pssi_clk_o.
pssi_data_o  out  BUS_W  PSSI data.

Behaviour:
- Reset (takes priority over everything, including mid-burst): FIFO emptied; div_cnt=0; pssi_clk_o=0; pssi_de_o=0; pssi_data_o=0; full_o=0; level_o=0; overflow_o=0; busy_o=0; FSM to IDLE.
- Clock divider: div_cnt counts 0..CLK_DIV-1 and wraps. pssi_clk_o is 0 for div_cnt < CLK_DIV/2 and 1 otherwise (registered).
- Update tick (utick): the clk_i edge on which div_cnt wraps to 0, which is also when pssi_clk_o falls. pssi_de_o and pssi_data_o change only on a utick, so they are stable for CLK_DIV/2 cycles before each rising edge.
- FIFO write:
  - wr_en_i with full_o=0: word stored, level increments.
  - wr_en_i with full_o=1: word dropped and overflow_o set, even if a pop happens in the same cycle.
  - Simultaneous accepted write and pop: level unchanged.
- Beats per word: NB = WORD_W/BUS_W. Beats go out least-significant slice first (word[BUS_W-1:0] first).
- FSM:
  - IDLE: on a utick, if level >= BURST_LEN, pop one word into the shift register and go to SEND. The first beat is driven with DE=1 on that same utick. A burst never starts on a partial FIFO, so no underrun can occur mid-burst.
  - SEND, on each utick:
    - If pssi_rdy_i=0: drive DE=0 and hold the current beat (no advance).
    - Otherwise advance to the next beat. After the last beat of a word, pop the next word on the same utick, with no bubble.
    - After the last beat of word BURST_LEN: DE=0, load the gap counter, go to GAP.
  - GAP: DE=0 for GAP_CYC uticks, then IDLE. If GAP_CYC=0, go straight to IDLE, which may start a new burst on the next utick.
- pssi_data_o keeps its last value while DE=0.
- busy_o=1 in SEND and GAP.
- Throughput: one beat per pssi_clk_o period while RDY is high. A burst takes BURST_LEN*NB pssi periods plus stalls.
- Parameter legality is checked at elaboration; an illegal value stops elaboration with an error.

Test Plan:
1. Defaults. Write 0x44332211, 0x88776655, 0xCCBBAA99, 0x00FFEEDD with RDY=1. Required: 16 DE-high beats 0x11,0x22,…,0xFF,0x00 on consecutive rising edges of pssi_clk_o; then DE low for 2 periods; level_o returns to 0; busy_o drops.
2. Write only 3 words (BURST_LEN=4). Required: DE stays 0 and busy_o=0. Writing a 4th word starts the burst on the next utick.
3. Drop RDY for 3 uticks after beat 0x33. Required: DE=0 for 3 periods with data held at 0x33; then 0x44 follows; total beat count is still 16 with no duplicates.
4. Write 17 words back-to-back with no uticks draining (or RDY=0 throughout). Required: full_o=1 at 16; the 17th write is dropped; overflow_o=1 and stays 1 until rst_i.
5. BUS_W=16, CLK_DIV=2. Write 0xAAAA5555, 0x12345678, 0x0BADF00D, 0xCAFEBABE. Required: beats 0x5555,0xAAAA,0x5678,0x1234,… with pssi_clk_o toggling every clk_i cycle.
6. Assert rst_i during beat 5 of a burst. Required: on the next cycle DE=0, pssi_clk_o=0, level_o=0 and busy_o=0. After release, a fresh 4-word write produces a clean burst starting at word 0, beat 0.

Source files
------------

// File: rtl/pssi_tx_burst_fifo.sv
// Sample-word FIFO feeding a burst serialiser for an STM32H7 PSSI receiver.
// Beats leave least-significant slice first; DE and data move only on the falling edge of pssi_clk_o.
module pssi_tx_burst_fifo #(
  parameter int unsigned BUS_W      = 8,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYC    = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wr_en_i,
  input  logic [WORD_W-1:0]           wr_data_i,
  output logic                        full_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        overflow_o,
  output logic                        busy_o,
  input  logic                        pssi_rdy_i,
  output logic                        pssi_clk_o,
  output logic                        pssi_de_o,
  output logic [BUS_W-1:0]            pssi_data_o
);
  localparam int unsigned NB  = WORD_W / BUS_W;
  localparam int unsigned LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned WCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned GCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [DW-1:0]  DivLast  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]  DivHalf  = DW'(CLK_DIV / 2);
  localparam logic [PW-1:0]  PtrLast  = PW'(FIFO_DEPTH - 1);
  localparam logic [LW-1:0]  LvlFull  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]  LvlBurst = LW'(BURST_LEN);
  localparam logic [BCW-1:0] BeatLast = BCW'(NB - 1);
  localparam logic [WCW-1:0] WordLast = WCW'(BURST_LEN - 1);
  localparam logic [GCW-1:0] GapLoad  = GCW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  if (!(BUS_W == 8 || BUS_W == 16)) begin : gen_bad_bus_w
    $error("BUS_W must be 8 or 16");
  end
  if (WORD_W < BUS_W || (WORD_W % BUS_W) != 0) begin : gen_bad_word_w
    $error("WORD_W must be a non-zero multiple of BUS_W");
  end
  if (FIFO_DEPTH == 0 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < BURST_LEN ||
      BURST_LEN == 0) begin : gen_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least BURST_LEN >= 1");
  end
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : gen_bad_div
    $error("CLK_DIV must be even and at least 2");
  end

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              ovf_q;
  logic [DW-1:0]     div_q, div_d;
  logic              pclk_q, utick;
  state_e            state_q, state_d;
  logic [WORD_W-1:0] sh_q, sh_d, head;
  logic [BUS_W-1:0]  data_q, data_d;
  logic              de_q, de_d;
  logic [BCW-1:0]    beat_q, beat_d;
  logic [WCW-1:0]    word_q, word_d;
  logic [GCW-1:0]    gap_q, gap_d;
  logic              push, pop;

  assign full_o      = (level_q == LvlFull);
  assign level_o     = level_q;
  assign overflow_o  = ovf_q;
  assign busy_o      = (state_q != StIdle);
  assign pssi_clk_o  = pclk_q;
  assign pssi_de_o   = de_q;
  assign pssi_data_o = data_q;

  assign push  = wr_en_i && !full_o;
  assign head  = mem_q[rd_ptr_q];
  assign utick = (div_q == DivLast);
  assign div_d = utick ? '0 : div_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    sh_d    = sh_q;
    data_d  = data_q;
    de_d    = de_q;
    beat_d  = beat_q;
    word_d  = word_q;
    gap_d   = gap_q;
    if (utick) begin
      unique case (state_q)
        StIdle: begin
          de_d = 1'b0;
          if (level_q >= LvlBurst) begin
            pop     = 1'b1;
            sh_d    = head >> BUS_W;
            data_d  = head[BUS_W-1:0];
            de_d    = 1'b1;
            beat_d  = '0;
            word_d  = '0;
            state_d = StSend;
          end
        end
        StSend: begin
          if (!pssi_rdy_i) begin
            de_d = 1'b0;
          end else if (beat_q == BeatLast) begin
            if (word_q == WordLast) begin
              de_d    = 1'b0;
              gap_d   = GapLoad;
              state_d = (GAP_CYC == 0) ? StIdle : StGap;
            end else begin
              // Next word follows the last beat with no bubble.
              pop    = 1'b1;
              sh_d   = head >> BUS_W;
              data_d = head[BUS_W-1:0];
              de_d   = 1'b1;
              beat_d = '0;
              word_d = word_q + 1'b1;
            end
          end else begin
            sh_d   = sh_q >> BUS_W;
            data_d = sh_q[BUS_W-1:0];
            de_d   = 1'b1;
            beat_d = beat_q + 1'b1;
          end
        end
        StGap: begin
          de_d = 1'b0;
          if (gap_q == '0) state_d = StIdle;
          else             gap_d   = gap_q - 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q    <= '0;
      pclk_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= StIdle;
      sh_q     <= '0;
      data_q   <= '0;
      de_q     <= 1'b0;
      beat_q   <= '0;
      word_q   <= '0;
      gap_q    <= '0;
    end else begin
      div_q  <= div_d;
      pclk_q <= (div_d >= DivHalf);
      if (push) wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (!push && pop) level_q <= level_q - 1'b1;
      // A write against a full FIFO is lost even if a pop frees a slot this cycle.
      if (wr_en_i && full_o) ovf_q <= 1'b1;
      state_q <= state_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      de_q    <= de_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      gap_q   <= gap_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: tb/tb_pssi_tx_burst_fifo.sv
// Bench for pssi_tx_burst_fifo: expected-beat queue fed from accepted writes, a bus monitor,
// random RDY/write traffic and directed corner cases, plus a 16-bit / divide-by-2 instance.
module tb_pssi_tx_burst_fifo;
  localparam int unsigned BUS_W   = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned BURST   = 4;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned GAP     = 2;
  localparam int unsigned NB      = WORD_W / BUS_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rdy = 1'b1;
  logic        full, ovf, busy, pclk, de;
  logic [4:0]  level;
  logic [7:0]  data;

  logic        wr_en16 = 1'b0;
  logic [31:0] wr_data16 = '0;
  logic        rdy16 = 1'b1;
  logic        full16, ovf16, busy16, pclk16, de16;
  logic [4:0]  level16;
  logic [15:0] data16;

  int unsigned      n_vec = 0;
  int unsigned      n_miss = 0;
  logic [BUS_W-1:0] exp_q[$];
  int unsigned      burst_beats = 0;
  int unsigned      gap_lows = 0;
  int unsigned      last_gap = 0;

  always #5 clk = ~clk;

  pssi_tx_burst_fifo #(
    .BUS_W(BUS_W), .WORD_W(WORD_W), .FIFO_DEPTH(DEPTH), .BURST_LEN(BURST),
    .CLK_DIV(CLK_DIV), .GAP_CYC(GAP)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data), .full_o(full),
    .level_o(level), .overflow_o(ovf), .busy_o(busy), .pssi_rdy_i(rdy),
    .pssi_clk_o(pclk), .pssi_de_o(de), .pssi_data_o(data)
  );

  pssi_tx_burst_fifo #(
    .BUS_W(16), .WORD_W(32), .FIFO_DEPTH(16), .BURST_LEN(4), .CLK_DIV(2), .GAP_CYC(2)
  ) u_dut16 (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en16), .wr_data_i(wr_data16), .full_o(full16),
    .level_o(level16), .overflow_o(ovf16), .busy_o(busy16), .pssi_rdy_i(rdy16),
    .pssi_clk_o(pclk16), .pssi_de_o(de16), .pssi_data_o(data16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Drive one write; keep=1 means the model expects it to be accepted.
  task automatic wr8(input logic [31:0] w, input bit keep);
    wr_en   = 1'b1;
    wr_data = w;
    if (keep) for (int b = 0; b < NB; b++) exp_q.push_back(w[b*BUS_W +: BUS_W]);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() >= BURST * NB) && n < 4000);
    repeat (2 * CLK_DIV) @(negedge clk);
    check_eq(tag, 32'(n < 4000), 32'd1);
  endtask

  // Bus monitor: compares every DE-high beat on a pssi_clk rising edge with the model queue.
  initial begin : monitor
    logic             prev_pclk, prev_busy;
    logic [BUS_W-1:0] last_beat, want;
    int unsigned      since;
    bit               rise_ok;
    prev_pclk = 1'b0; prev_busy = 1'b0; last_beat = '0; since = 0; rise_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pclk = 1'b0; prev_busy = 1'b0; last_beat = '0; since = 0; rise_ok = 1'b0;
        burst_beats = 0; gap_lows = 0;
      end else begin
        since++;
        if (pclk && !prev_pclk) begin
          if (rise_ok) check_eq("pclk_period", since, CLK_DIV);
          rise_ok = 1'b1;
          since = 0;
          if (de) begin
            check_eq("beat_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              want = exp_q.pop_front();
              check_eq("beat_data", 32'(data), 32'(want));
            end
            last_beat = data;
            burst_beats++;
          end else begin
            check_eq("held_data", 32'(data), 32'(last_beat));
            if (busy && burst_beats == BURST * NB) gap_lows++;
          end
        end
        if (prev_busy && !busy) begin
          check_eq("burst_beats", burst_beats, BURST * NB);
          check_eq("gap_min", 32'(gap_lows >= GAP), 32'd1);
          last_gap = gap_lows;
          burst_beats = 0;
          gap_lows = 0;
        end
        prev_pclk = pclk;
        prev_busy = busy;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] w16 [4];
    logic [15:0] e16 [8];
    logic [31:0] plan [4];
    logic        prev, p16, d44_de;
    logic [7:0]  d44;
    int unsigned n, lows, toggles, beats16, rem;
    bit          found;

    plan[0] = 32'h44332211; plan[1] = 32'h88776655; plan[2] = 32'hCCBBAA99; plan[3] = 32'h00FFEEDD;
    w16[0] = 32'hAAAA5555; w16[1] = 32'h12345678; w16[2] = 32'h0BADF00D; w16[3] = 32'hCAFEBABE;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_de", 32'(de), 32'd0);
    check_eq("rst_pclk", 32'(pclk), 32'd0);
    check_eq("rst_data", 32'(data), 32'd0);
    rst = 1'b0;

    // 16-bit bus, pssi_clk at clk/2
    for (int i = 0; i < 4; i++) begin
      e16[2*i]   = w16[i][15:0];
      e16[2*i+1] = w16[i][31:16];
    end
    for (int i = 0; i < 4; i++) begin
      wr_en16 = 1'b1; wr_data16 = w16[i];
      @(negedge clk);
    end
    wr_en16 = 1'b0;
    p16 = pclk16; toggles = 0; beats16 = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pclk16 != p16) toggles++;
      if (pclk16 && !p16 && de16) begin
        if (beats16 < 8) check_eq("bus16_beat", 32'(data16), 32'(e16[beats16]));
        beats16++;
      end
      p16 = pclk16;
    end
    check_eq("bus16_toggles", toggles, 32'd60);
    check_eq("bus16_count", beats16, 32'd8);
    check_eq("bus16_busy", 32'(busy16), 32'd0);
    check_eq("bus16_level", 32'(level16), 32'd0);

    // Basic burst with the reference words
    for (int i = 0; i < 4; i++) wr8(plan[i], 1'b1);
    wait_idle("basic_drain");
    check_eq("basic_level", 32'(level), 32'd0);
    check_eq("basic_left", 32'(exp_q.size()), 32'd0);
    check_eq("basic_gap", last_gap, GAP);

    // Partial FIFO must not start a burst
    for (int i = 0; i < 3; i++) wr8($urandom(), 1'b1);
    repeat (10 * CLK_DIV) @(negedge clk);
    check_eq("partial_busy", 32'(busy), 32'd0);
    check_eq("partial_de", 32'(de), 32'd0);
    check_eq("partial_level", 32'(level), 32'd3);
    wr8($urandom(), 1'b1);
    n = 0;
    while (!busy && n < 2 * CLK_DIV) begin
      @(negedge clk);
      n++;
    end
    check_eq("start_latency", 32'(busy && n <= CLK_DIV), 32'd1);
    wait_idle("partial_drain");

    // RDY stall after the 0x33 beat
    for (int i = 0; i < 4; i++) wr8(plan[i], 1'b1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      prev = pclk;
      @(negedge clk);
      if (pclk && !prev && de && data == 8'h33) found = 1'b1;
    end
    check_eq("stall_found33", 32'(found), 32'd1);
    rdy = 1'b0; lows = 0; d44_de = 1'b0; d44 = '0;
    for (int i = 1; i <= 100 && !d44_de; i++) begin
      prev = pclk;
      @(negedge clk);
      if (i == 3 * CLK_DIV) rdy = 1'b1;
      if (pclk && !prev) begin
        if (de) begin
          d44_de = 1'b1;
          d44 = data;
        end else begin
          lows++;
        end
      end
    end
    check_eq("stall_lows", lows, 32'd3);
    check_eq("stall_next", 32'(d44), 32'h44);
    wait_idle("stall_drain");

    // Random writes against random RDY
    for (int i = 0; i < 800; i++) begin
      rdy = ($urandom_range(3) != 0);
      if ($urandom_range(2) == 0 && exp_q.size() < 12 * NB) wr8($urandom(), 1'b1);
      else @(negedge clk);
    end
    rdy = 1'b1;
    wait_idle("rand_drain");
    rem = exp_q.size() / NB;
    check_eq("rand_level", 32'(level), rem);
    if (rem != 0) for (int i = rem; i < BURST; i++) wr8($urandom(), 1'b1);
    wait_idle("rand_flush");
    check_eq("rand_left", 32'(exp_q.size()), 32'd0);
    check_eq("rand_level0", 32'(level), 32'd0);

    // Fill to overflow while the burst is stalled on beat 0
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) wr8($urandom(), 1'b1);
    n = 0;
    while (!busy && n < 4 * CLK_DIV) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * CLK_DIV) @(negedge clk);
    check_eq("ovf_stall_level", 32'(level), 32'd3);
    for (int i = 0; i < 12; i++) wr8($urandom(), 1'b1);
    check_eq("ovf_level15", 32'(level), 32'd15);
    check_eq("ovf_notfull", 32'(full), 32'd0);
    wr8($urandom(), 1'b1);
    check_eq("ovf_level16", 32'(level), 32'd16);
    check_eq("ovf_full", 32'(full), 32'd1);
    check_eq("ovf_before", 32'(ovf), 32'd0);
    wr8($urandom(), 1'b0);
    check_eq("ovf_set", 32'(ovf), 32'd1);
    check_eq("ovf_level_kept", 32'(level), 32'd16);
    repeat (3 * CLK_DIV) @(negedge clk);
    check_eq("ovf_stall_hold", 32'(level), 32'd16);
    rdy = 1'b1;
    wait_idle("ovf_drain");
    check_eq("ovf_left_level", 32'(level), 32'd1);
    check_eq("ovf_sticky", 32'(ovf), 32'd1);

    // Reset in the middle of a burst
    for (int i = 0; i < 3; i++) wr8($urandom(), 1'b1);
    n = 0;
    while (burst_beats < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("midrst_reached", 32'(burst_beats >= 5), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("midrst_de", 32'(de), 32'd0);
    check_eq("midrst_pclk", 32'(pclk), 32'd0);
    check_eq("midrst_level", 32'(level), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) wr8($urandom(), 1'b1);
    wait_idle("postrst_drain");
    check_eq("postrst_left", 32'(exp_q.size()), 32'd0);
    check_eq("postrst_level", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
